// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU functions, branch conditions, status,
// and the packed condition-code record.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator; also used by the Fetch-stage
// predictor checker, so it knows nothing about icodes.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] i_ifun,
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  output logic       o_cnd,
  output logic       o_bad
);

  logic w_x;
  assign w_x = i_sf ^ i_of;

  always_comb begin
    o_cnd = 1'b0;
    o_bad = 1'b0;
    case (i_ifun)
      C_YES:   o_cnd = 1'b1;
      C_LE:    o_cnd = w_x | i_zf;
      C_L:     o_cnd = w_x;
      C_E:     o_cnd = i_zf;
      C_NE:    o_cnd = ~i_zf;
      C_GE:    o_cnd = ~w_x;
      C_G:     o_cnd = ~w_x & ~i_zf;
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Execute-stage condition-code register plus jXX/cmov condition evaluation.
// Conditions read the registered codes only; an OPq's update is not bypassed.
module cc_unit
  import y86_pkg::cc_t;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] RESET_CC = 3'b100,
  parameter logic [3:0] I_OPQ    = 4'h6,
  parameter logic [3:0] I_JXX    = 4'h7,
  parameter logic [3:0] I_RRMOVQ = 4'h2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  input  logic             m_exc,
  input  logic             w_exc,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             e_cnd,
  output logic             cc_updated
  ,
  output logic             bad_cond
);

  cc_t  r_cc;
  logic r_upd;
  logic w_set_cc;
  logic w_is_cond;
  logic w_cnd;
  logic w_bad;
  cc_t  w_cc_new;

  // A faulting instruction further down the pipe squashes this cycle's update.
  assign w_set_cc = (e_icode == I_OPQ) & ~m_exc & ~w_exc;

  assign w_cc_new.zf = (alu_result == '0);
  assign w_cc_new.sf = alu_result[WIDTH-1];
  // Only add/sub can overflow; logical ops clear OF whatever the ALU reports.
  assign w_cc_new.of = alu_ovf & ((e_ifun == 4'h0) | (e_ifun == 4'h1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc  <= cc_t'(RESET_CC);
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_set_cc;
      if (w_set_cc) r_cc <= w_cc_new;
    end
  end

  cond_eval u_cond (
    .i_ifun (e_ifun),
    .i_zf   (r_cc.zf),
    .i_sf   (r_cc.sf),
    .i_of   (r_cc.of),
    .o_cnd  (w_cnd),
    .o_bad  (w_bad)
  );

  assign w_is_cond  = (e_icode == I_JXX) | (e_icode == I_RRMOVQ);
  assign e_cnd      = w_is_cond & w_cnd;
  assign bad_cond   = w_is_cond & w_bad;
  assign zf         = r_cc.zf;
  assign sf         = r_cc.sf;
  assign of         = r_cc.of;
  assign cc_updated = r_upd;

endmodule

// File: tb/tb_cc_unit.sv
// Randomized bench for cc_unit: a behavioural flag model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cc_unit;

  localparam int W = 64;
  localparam logic [3:0] NOP = 4'h1, RRM = 4'h2, OPQ = 4'h6, JXX = 4'h7;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   e_icode, e_ifun;
  logic [W-1:0] alu_result;
  logic         alu_ovf, m_exc, w_exc;
  logic         zf, sf, of, e_cnd, cc_updated, bad_cond;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  // model state
  bit m_zf, m_sf, m_of, m_upd;

  always #5 clk = ~clk;

  cc_unit dut (
    .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .m_exc(m_exc), .w_exc(w_exc),
    .zf(zf), .sf(sf), .of(of), .e_cnd(e_cnd), .cc_updated(cc_updated),
    .bad_cond(bad_cond)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Architectural condition semantics: signed less-than is SF xor OF.
  function automatic bit model_cnd(input logic [3:0] f, input bit z, input bit s, input bit o);
    bit lt;
    lt = s ^ o;
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_zf = 1; m_sf = 0; m_of = 0; m_upd = 0;
    end else if (e_icode == OPQ && !m_exc && !w_exc) begin
      m_zf  = (alu_result == 0);
      m_sf  = ($signed(alu_result) < 0);
      m_of  = alu_ovf && (e_ifun < 2);
      m_upd = 1;
    end else begin
      m_upd = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit cond_ins;
      cond_ins = (e_icode == JXX) || (e_icode == RRM);
      chk("zf", zf, m_zf);
      chk("sf", sf, m_sf);
      chk("of", of, m_of);
      chk("cc_updated", cc_updated, m_upd);
      chk("e_cnd", e_cnd, cond_ins && model_cnd(e_ifun, m_zf, m_sf, m_of));
      chk("bad_cond", bad_cond, cond_ins && (e_ifun > 6));
    end
  end

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] res,
                       input bit ovf, input bit me, input bit we, input bit r);
    @(posedge clk); #1;
    e_icode = ic; e_ifun = fn; alu_result = res; alu_ovf = ovf;
    m_exc = me; w_exc = we; rst = r;
  endtask

  task automatic lit_flags(input string tag, input bit z, input bit s, input bit o, input bit u);
    @(negedge clk); #1;
    chk({tag, ".zf"}, zf, z);
    chk({tag, ".sf"}, sf, s);
    chk({tag, ".of"}, of, o);
    chk({tag, ".upd"}, cc_updated, u);
  endtask

  initial begin
    rst = 1; e_icode = NOP; e_ifun = 0; alu_result = 0; alu_ovf = 0; m_exc = 0; w_exc = 0;
    drive(NOP, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    cmp_en = 1;

    // reset value, then je
    drive(JXX, 3, 0, 0, 0, 0, 0);
    lit_flags("reset", 1, 0, 0, 0);
    chk("reset.je", e_cnd, 1);

    // add overflowing into the minimum value
    drive(OPQ, 0, MINV, 1, 0, 0, 0);
    drive(JXX, 2, 0, 0, 0, 0, 0);
    lit_flags("addovf", 0, 1, 1, 1);
    chk("addovf.jl", e_cnd, 0);
    drive(JXX, 5, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("addovf.jge", e_cnd, 1);

    // AND clears OF; then cmovle
    drive(OPQ, 2, 0, 1, 0, 0, 0);
    drive(RRM, 1, 0, 0, 0, 0, 0);
    lit_flags("and", 1, 0, 0, 1);
    chk("and.cmovle", e_cnd, 1);

    // exception inhibit from {0,1,0}
    drive(OPQ, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    drive(OPQ, 0, 0, 0, 1, 0, 0);
    lit_flags("mexc", 0, 1, 0, 1);
    drive(OPQ, 0, 0, 0, 0, 1, 0);
    lit_flags("wexc", 0, 1, 0, 0);
    drive(NOP, 0, 0, 0, 0, 0, 0);
    lit_flags("wexc2", 0, 1, 0, 0);

    // NOP holds; jne / bad ifun
    drive(OPQ, 0, 0, 0, 0, 0, 0);
    drive(NOP, 0, 5, 0, 0, 0, 0);
    lit_flags("opz", 1, 0, 0, 1);
    drive(JXX, 4, 0, 0, 0, 0, 0);
    lit_flags("nophold", 1, 0, 0, 0);
    chk("jne", e_cnd, 0);
    drive(JXX, 9, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("bad.cnd", e_cnd, 0);
    chk("bad.flag", bad_cond, 1);

    // reset overrides same-edge update
    drive(OPQ, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    drive(OPQ, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
    lit_flags("prerst", 0, 1, 0, 1);
    drive(NOP, 0, 0, 0, 0, 0, 0);
    lit_flags("midrst", 1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  ic;
      logic [63:0] res;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: ic = OPQ;
        4, 5:       ic = JXX;
        6:          ic = RRM;
        7:          ic = NOP;
        default:    ic = 4'($urandom);
      endcase
      sel = $urandom_range(0, 7);
      case (sel)
        0:       res = 0;
        1:       res = MINV;
        2:       res = 64'hFFFF_FFFF_FFFF_FFFF;
        default: res = {$urandom, $urandom};
      endcase
      drive(ic, 4'($urandom_range(0, 15)), res, 1'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    drive(NOP, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
